part_2_sample_packer: RTL and testbench

Upstream export stage for the partition-2 initiator. It samples the per-channel partition inputs `{wen_k, i_data_k}` on each rising edge of the matching mission clock, observed in the utility clock domain. Samples are buffered in per-channel FIFOs and presented one at a time, round-robin, as 9-bit joined vectors to the fringe put logic over a valid/ready handshake. It also drives per-channel freeze requests so the mission clock generator stalls before any sample can be lost.

---
 rtl/part_2_sample_packer.sv | 153 +++++++++++++++
 tb/tb_part_2_sample_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/part_2_sample_packer.sv
// Partition-2 export stage: samples each mission channel on its clock rise, buffers per channel,
// and hands joined {wen, data} vectors out round-robin over a valid/ready handshake.
module part_2_sample_packer #(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_CH-1:0]    clk_h_i,
    input  logic [N_CH-1:0]    wen_i,
    input  logic [N_CH*DW-1:0] data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [1:0]         out_ch_o,
    output logic [DW:0]        out_data_o,
    output logic [N_CH-1:0]    freeze_o,
    output logic [N_CH-1:0]    ovf_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt   = CW'(DEPTH);
    localparam logic [CW-1:0] FreezeCnt = CW'(DEPTH - 1);

    typedef enum logic {StEmpty, StFull} out_state_e;

    logic [N_CH-1:0] clk_h_q;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] nonempty, full, push, pop;
    logic [N_CH-1:0] ovf_q, ovf_d, freeze_q, freeze_d;

    logic [DW:0]     mem_q    [N_CH][DEPTH];
    logic [AW-1:0]   wr_ptr_q [N_CH];
    logic [AW-1:0]   wr_ptr_d [N_CH];
    logic [AW-1:0]   rd_ptr_q [N_CH];
    logic [AW-1:0]   rd_ptr_d [N_CH];
    logic [CW-1:0]   count_q  [N_CH];
    logic [CW-1:0]   count_d  [N_CH];

    out_state_e  state_q, state_d;
    logic [1:0]  rr_q, rr_d, ch_q, ch_d, grant;
    logic [DW:0] data_q, data_d;
    logic        load, found;

    assign rise = clk_h_i & ~clk_h_q;
    assign load = (state_q == StEmpty) || out_ready_i;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            nonempty[k] = (count_q[k] != '0);
            full[k]     = (count_q[k] == FullCnt);
        end
    end

    // Round-robin search starting one past the last granted channel; only
    // FIFOs already holding data this cycle are eligible.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        grant = rr_q;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = (32'(rr_q) + i) % N_CH;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                grant = 2'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (load && found) begin
            pop[grant] = 1'b1;
        end
    end

    // A full FIFO still accepts a sample when it is popped in the same cycle.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            push[k]     = rise[k] & (~full[k] | pop[k]);
            ovf_d[k]    = ovf_q[k] | (rise[k] & full[k] & ~pop[k]);
            wr_ptr_d[k] = wr_ptr_q[k] + AW'(push[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + AW'(pop[k]);
            count_d[k]  = count_q[k] + CW'(push[k]) - CW'(pop[k]);
            freeze_d[k] = (count_d[k] >= FreezeCnt);
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        data_d  = data_q;
        rr_d    = rr_q;
        if (load) begin
            if (found) begin
                state_d = StFull;
                ch_d    = grant;
                data_d  = mem_q[grant][rd_ptr_q[grant]];
                rr_d    = grant;
            end else begin
                state_d = StEmpty;
            end
        end
    end

    // Storage array carries no reset; validity is tracked by the counters.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_CH; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= {wen_i[k], data_i[k*DW +: DW]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_h_q  <= '0;
            ovf_q    <= '0;
            freeze_q <= '0;
            state_q  <= StEmpty;
            rr_q     <= 2'(N_CH - 1);
            ch_q     <= '0;
            data_q   <= '0;
            for (int k = 0; k < N_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
        end else begin
            clk_h_q  <= clk_h_i;
            ovf_q    <= ovf_d;
            freeze_q <= freeze_d;
            state_q  <= state_d;
            rr_q     <= rr_d;
            ch_q     <= ch_d;
            data_q   <= data_d;
            for (int k = 0; k < N_CH; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                count_q[k]  <= count_d[k];
            end
        end
    end

    assign out_valid_o = (state_q == StFull);
    assign out_ch_o    = ch_q;
    assign out_data_o  = data_q;
    assign freeze_o    = freeze_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_part_2_sample_packer.sv
// Bench for part_2_sample_packer: queue-based reference model feeds an expected-output
// scoreboard that an independent monitor drains on each accepted vector.
module tb_part_2_sample_packer;

    localparam int N_CH  = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_CH-1:0]    clk_h = '0;
    logic [N_CH-1:0]    wen = '0;
    logic [N_CH*DW-1:0] data = '0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [1:0]         out_ch;
    logic [DW:0]        out_data;
    logic [N_CH-1:0]    freeze;
    logic [N_CH-1:0]    ovf;

    always #5 clk = ~clk;

    part_2_sample_packer #(.N_CH(N_CH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clk_h_i    (clk_h),
        .wen_i      (wen),
        .data_i     (data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_ch_o   (out_ch),
        .out_data_o (out_data),
        .freeze_o   (freeze),
        .ovf_o      (ovf)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [DW:0] data;
    } txn_t;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    // Reference model state: what the design holds during the current cycle.
    logic [DW:0]        q_m [N_CH][$];
    txn_t               exp_q[$];
    bit                 m_valid;
    int                 m_rr;
    logic [N_CH-1:0]    m_prev, m_ovf, m_freeze;
    // Inputs that were presented at the most recent clock edge.
    logic [N_CH-1:0]    p_clk, p_wen;
    logic [N_CH*DW-1:0] p_data;
    logic               p_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) q_m[k].delete();
        exp_q.delete();
        m_valid  = 1'b0;
        m_rr     = N_CH - 1;
        m_prev   = '0;
        m_ovf    = '0;
        m_freeze = '0;
        p_clk    = '0;
        p_wen    = '0;
        p_data   = '0;
        p_rdy    = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs seen at that edge.
    task automatic model_step();
        logic [N_CH-1:0] rise;
        bit              load, found;
        int              g;
        logic [DW:0]     item;
        rise   = p_clk & ~m_prev;
        m_prev = p_clk;
        load   = !m_valid || p_rdy;
        found  = 1'b0;
        g      = 0;
        item   = '0;
        if (load) begin
            for (int i = 1; i <= N_CH; i++) begin
                int c;
                c = (m_rr + i) % N_CH;
                if (!found && q_m[c].size() > 0) begin
                    found = 1'b1;
                    g     = c;
                end
            end
        end
        if (found) item = q_m[g].pop_front();
        for (int k = 0; k < N_CH; k++) begin
            if (rise[k]) begin
                if (q_m[k].size() < DEPTH) q_m[k].push_back({p_wen[k], p_data[k*DW +: DW]});
                else m_ovf[k] = 1'b1;
            end
        end
        if (load) begin
            if (found) begin
                m_valid = 1'b1;
                m_rr    = g;
                exp_q.push_back({2'(g), item});
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int k = 0; k < N_CH; k++) m_freeze[k] = (q_m[k].size() >= DEPTH - 1);
    endtask

    task automatic step(input logic [N_CH-1:0] c, input logic [N_CH-1:0] w,
                        input logic [N_CH*DW-1:0] d, input logic r);
        @(posedge clk);
        #1;
        model_step();
        clk_h = c; wen = w; data = d; out_ready = r;
        p_clk = c; p_wen = w; p_data = d; p_rdy = r;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step('0, '0, '0, r);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ch"}, 32'(out_ch), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_freeze"}, 32'(freeze), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    // Monitor: cycle-level flags against the model, vectors against the scoreboard.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst_n && !done) begin
                chk("out_valid", 32'(out_valid), 32'(m_valid));
                chk("freeze", 32'(freeze), 32'(m_freeze));
                chk("ovf", 32'(ovf), 32'(m_ovf));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_vector: got ch=%0d data=%0h expected none",
                                 out_ch, out_data);
                    end else begin
                        t = exp_q.pop_front();
                        chk("out_ch", 32'(out_ch), 32'(t.ch));
                        chk("out_data", 32'(out_data), 32'(t.data));
                    end
                end
            end
        end
    end

    initial begin
        logic [N_CH-1:0] cur;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single sample on ch0.
        step(3'b001, 3'b001, 24'h0000A5, 1'b1);
        idle(5, 1'b1);

        // Simultaneous rise on all channels.
        step(3'b111, 3'b000, 24'h332211, 1'b1);
        idle(6, 1'b1);

        // Backpressure on ch1: six rises, the last one overflows.
        for (int i = 1; i <= 6; i++) begin
            step(3'b010, 3'b000, 24'(i) << DW, 1'b0);
            step(3'b000, 3'b000, '0, 1'b0);
        end
        @(negedge clk);
        chk("ovf_ch1_set", 32'(ovf[1]), 32'd1);
        idle(8, 1'b1);

        // Fill ch0 completely, then push on the same cycle as a pop.
        for (int i = 1; i <= 5; i++) begin
            step(3'b001, 3'b000, 24'(8'h40 + i), 1'b0);
            step(3'b000, 3'b000, '0, 1'b0);
        end
        step(3'b001, 3'b001, 24'h00004F, 1'b1);
        idle(8, 1'b1);
        chk("ovf_ch0_clear", 32'(ovf[0]), 32'd0);

        // Asynchronous reset with work queued.
        step(3'b011, 3'b011, 24'h007766, 1'b0);
        step(3'b000, 3'b000, '0, 1'b0);
        step(3'b011, 3'b000, 24'h009988, 1'b0);
        step(3'b000, 3'b000, '0, 1'b0);
        @(negedge clk);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        clk_h = '0; wen = '0; data = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b100, 3'b100, 24'hC30000, 1'b0);
        step(3'b001, 3'b001, 24'h00003C, 1'b0);
        step(3'b000, 3'b000, '0, 1'b0);
        @(negedge clk);
        chk("post_reset_ch", 32'(out_ch), 32'd2);
        idle(6, 1'b1);

        // Randomized traffic with alternating light and heavy backpressure.
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            cur = cur ^ N_CH'($urandom);
            step(cur, N_CH'($urandom), N_CH*DW'($urandom),
                 ($urandom_range(0, 9) < (((i / 300) % 2 == 0) ? 8 : 3)));
        end
        idle(40, 1'b1);
        @(negedge clk);
        chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
